// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Register map and TCTL bit layout shared by the interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int unsigned TCNT_OFF  = 0;
    localparam int unsigned TLIM_OFF  = 4;
    localparam int unsigned TCTL_OFF  = 8;

    localparam int unsigned READY_BIT = 0;
    localparam int unsigned OVR_BIT   = 2;
    localparam int unsigned IE_BIT    = 8;

    // Word index inside the 16-byte window (byte offset / 4).
    typedef enum logic [1:0] {
        REG_TCNT = 2'(TCNT_OFF / 4),
        REG_TLIM = 2'(TLIM_OFF / 4),
        REG_TCTL = 2'(TCTL_OFF / 4),
        REG_RSVD = 2'd3
    } reg_sel_e;

    function automatic logic [IE_BIT:0] tctl_pack(
        input logic ready,
        input logic ovr,
        input logic ie
    );
        logic [IE_BIT:0] v;
        v            = '0;
        v[READY_BIT] = ready;
        v[OVR_BIT]   = ovr;
        v[IE_BIT]    = ie;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Prescaler producing a one-cycle tick every DIV clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned        c_W    = $clog2(DIV);
    localparam logic [c_W-1:0]     c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/timer_device.sv
`default_nettype none
// ============================================================================
// Module      : timer_device
// Description : Bus-mapped interval timer with limit wrap, sticky ready,
//               overrun detection and registered interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_device
    import timer_pkg::*;
#(
    parameter int unsigned                ADDR_BIT_WIDTH = 32,
    parameter int unsigned                DATA_BIT_WIDTH = 32,
    parameter logic [ADDR_BIT_WIDTH-1:0]  BASE_ADDR      = 32'hF000_0020,
    parameter int unsigned                DIV            = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrtEn,
    input  logic [ADDR_BIT_WIDTH-1:0]  addr,
    inout  wire  [DATA_BIT_WIDTH-1:0]  dbus,
    output logic                       intr
);

    localparam logic [DATA_BIT_WIDTH-1:0] c_ONE = DATA_BIT_WIDTH'(1);

    logic                       w_sel;
    logic                       w_wr;
    logic                       w_wr_tcnt;
    logic                       w_wr_tlim;
    logic                       w_wr_tctl;
    logic                       w_tick;
    logic                       w_hit;
    logic                       w_rdy_sw;
    logic                       w_ovr_sw;
    logic                       w_unused;
    reg_sel_e                   w_reg;
    logic [DATA_BIT_WIDTH-1:0]  w_rdata;

    logic [DATA_BIT_WIDTH-1:0]  r_tcnt;
    logic [DATA_BIT_WIDTH-1:0]  r_tlim;
    logic                       r_ready;
    logic                       r_ovr;
    logic                       r_ie;
    logic                       r_intr;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_sel     = (addr[ADDR_BIT_WIDTH-1:4] == BASE_ADDR[ADDR_BIT_WIDTH-1:4]);
    assign w_reg     = reg_sel_e'(addr[3:2]);
    assign w_unused  = ^addr[1:0];
    assign w_wr      = w_sel && wrtEn;
    assign w_wr_tcnt = w_wr && (w_reg == REG_TCNT);
    assign w_wr_tlim = w_wr && (w_reg == REG_TLIM);
    assign w_wr_tctl = w_wr && (w_reg == REG_TCTL);

    // A TCNT write restarts the prescaler, so a coincident tick is dropped.
    tick_gen #(
        .DIV   (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_wr_tcnt),
        .tick  (w_tick)
    );

    assign w_hit = w_tick && !w_wr_tcnt && (r_tlim != '0) && (r_tcnt == r_tlim - c_ONE);

    // Status after the software write-0-to-clear, before hardware sets.
    assign w_rdy_sw = w_wr_tctl ? (r_ready & dbus[READY_BIT]) : r_ready;
    assign w_ovr_sw = w_wr_tctl ? (r_ovr   & dbus[OVR_BIT])   : r_ovr;

    // ------------------------------------------------------------------
    // Register file and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt  <= '0;
            r_tlim  <= '0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
            r_ie    <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            if (w_wr_tcnt) begin
                r_tcnt <= dbus;
            end else if (w_hit) begin
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_tcnt <= r_tcnt + c_ONE;
            end

            if (w_wr_tlim) begin
                r_tlim <= dbus;
            end

            if (w_wr_tctl) begin
                r_ie <= dbus[IE_BIT];
            end

            // Hardware set beats the software clear of ready; overrun only
            // counts an event software has not consumed in this same cycle.
            r_ready <= w_hit | w_rdy_sw;
            r_ovr   <= w_ovr_sw | (w_hit & w_rdy_sw);
            r_intr  <= r_ready & r_ie;
        end
    end

    assign intr = r_intr;

    // ------------------------------------------------------------------
    // Read path and tristate driver
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_TCNT: w_rdata = r_tcnt;
            REG_TLIM: w_rdata = r_tlim;
            REG_TCTL: w_rdata = DATA_BIT_WIDTH'(tctl_pack(r_ready, r_ovr, r_ie));
            default:  w_rdata = '0;
        endcase
    end

    assign dbus = (w_sel && !wrtEn) ? w_rdata : {DATA_BIT_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_timer_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_device
// Description : Directed plus randomized bus traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_device;

    localparam int unsigned DIV  = 4;
    localparam logic [31:0] BASE = 32'hF000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrtEn = 1'b0;
    logic [31:0] addr = BASE;
    logic [31:0] tb_wdata = '0;
    logic        tb_drv = 1'b0;
    wire  [31:0] dbus;
    logic        intr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state
    logic [31:0] m_cnt = '0, m_lim = '0;
    logic        m_ready = 0, m_ovr = 0, m_ie = 0, m_intr = 0;
    int unsigned m_age = 0;

    assign dbus = tb_drv ? tb_wdata : 32'bz;

    always #5 clk = ~clk;

    timer_device #(
        .ADDR_BIT_WIDTH (32),
        .DATA_BIT_WIDTH (32),
        .BASE_ADDR      (BASE),
        .DIV            (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wrtEn (wrtEn),
        .addr  (addr),
        .dbus  (dbus),
        .intr  (intr)
    );

    function automatic bit m_sel(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        case (a[3:2])
            2'd0: v = m_cnt;
            2'd1: v = m_lim;
            2'd2: begin v[0] = m_ready; v[2] = m_ovr; v[8] = m_ie; end
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock edge of the timer, from the rules: ticks every DIV cycles
    // since the last prescaler restart, limit wrap, sticky flags.
    task automatic model_edge();
        bit          wr, tick, hit, rdy, ovr;
        logic [31:0] d;
        if (reset) begin
            m_cnt = '0; m_lim = '0; m_ready = 0; m_ovr = 0; m_ie = 0; m_intr = 0;
            m_age = 0;
            return;
        end
        wr   = wrtEn && m_sel(addr);
        d    = tb_wdata;
        tick = (m_age % DIV) == DIV - 1;
        hit  = 0;
        m_intr = m_ready & m_ie;
        if (wr && addr[3:2] == 2'd0) begin
            m_cnt = d;
            m_age = 0;
        end else begin
            if (tick) begin
                if (m_lim != 0 && m_cnt == m_lim - 32'd1) begin
                    hit = 1; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 32'd1;
                end
            end
            m_age = m_age + 1;
        end
        rdy = m_ready; ovr = m_ovr;
        if (wr && addr[3:2] == 2'd2) begin
            rdy = rdy & d[0];
            ovr = ovr & d[2];
            m_ie = d[8];
        end
        if (hit) begin
            ovr = ovr | rdy;
            rdy = 1;
        end
        m_ready = rdy; m_ovr = ovr;
        if (wr && addr[3:2] == 2'd1) m_lim = d;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, sample mid-cycle, clock, advance the model.
    task automatic do_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input string tag, input bit has_lit, input logic [31:0] lit,
                            input int intr_lit);
        wrtEn = w; addr = a; tb_wdata = d; tb_drv = w;
        #4;
        if (chk_en) begin
            if (!w) begin
                if (m_sel(a)) begin
                    check_eq(tag, dbus, m_read(a));
                end else begin
                    checks++;
                    assert (dbus === 32'bz || dbus === 32'b0) else begin
                        errors++;
                        $error("FAIL %s/float: observed %h expected undriven", tag, dbus);
                    end
                end
                if (has_lit) check_eq({tag, "/lit"}, dbus, lit);
            end
            check_eq({tag, "/intr"}, {31'b0, intr}, {31'b0, m_intr});
            if (intr_lit >= 0) check_eq({tag, "/intr_lit"}, {31'b0, intr}, 32'(intr_lit));
        end
        @(posedge clk);
        model_edge();
        #1;
        tb_drv = 1'b0; wrtEn = 1'b0;
    endtask

    task automatic rd(input int unsigned off, input string tag);
        do_cycle(1'b0, BASE | off, 32'b0, tag, 1'b0, 32'b0, -1);
    endtask

    task automatic rd_lit(input int unsigned off, input logic [31:0] exp,
                          input string tag, input int intr_lit);
        do_cycle(1'b0, BASE | off, 32'b0, tag, 1'b1, exp, intr_lit);
    endtask

    task automatic wr(input int unsigned off, input logic [31:0] d, input string tag);
        do_cycle(1'b1, BASE | off, d, tag, 1'b0, 32'b0, -1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(0, "pre_reset");
        rd(0, "pre_reset");
        reset = 1'b0;
        chk_en = 1'b1;

        rd_lit(0,  32'h0, "rst_tcnt", 0);
        rd_lit(4,  32'h0, "rst_tlim", 0);
        rd_lit(8,  32'h0, "rst_tctl", 0);
        rd_lit(12, 32'h0, "rst_rsvd", 0);

        // Limit of 3 with a freshly restarted prescaler
        wr(4, 32'd3, "wr_tlim3");
        wr(0, 32'd0, "wr_tcnt0");
        do_cycle(1'b0, (BASE | 32'd4) & ~32'h1000_0000, 32'b0, "alias_io0", 1'b0, 32'b0, -1);
        for (int i = 2; i <= 12; i++) begin
            if (i == 5)      rd_lit(0, 32'd1, "cnt_at4", -1);
            else if (i == 9) rd_lit(0, 32'd2, "cnt_at8", -1);
            else             rd(0, "run_lim3");
        end
        rd_lit(8, 32'h1, "ready_first", 0);
        rd_lit(0, 32'h0, "cnt_wrapped", -1);

        // Enable interrupt while clearing ready
        wr(8, 32'h100, "wr_ie");
        for (int i = 0; i < 9; i++) rd(0, "run_ie");
        rd_lit(8, 32'h101, "ready_ie", 0);
        rd_lit(8, 32'h101, "intr_lag", 1);

        // Two further hits without clearing
        for (int i = 0; i < 22; i++) rd(0, "run_ovr");
        rd_lit(8, 32'h105, "overrun", 1);
        wr(8, 32'h004, "clr_ready_only");
        rd_lit(8, 32'h004, "ovr_kept", -1);

        // Free-running wrap of TCNT
        wr(4, 32'd0, "wr_tlim0");
        wr(0, 32'hFFFF_FFFF, "wr_tcnt_max");
        for (int i = 0; i < 3; i++) rd(0, "run_free");
        rd_lit(0, 32'hFFFF_FFFF, "cnt_max", -1);
        rd_lit(0, 32'h0, "cnt_wrap32", -1);
        rd(0, "run_free");
        rd(0, "run_free");
        wr(0, 32'h10, "wr_on_tick");
        rd_lit(0, 32'h10, "wr_wins", -1);
        rd(0, "run_post");
        rd(0, "run_post");
        rd_lit(0, 32'h10, "tick_restart_a", -1);
        rd_lit(0, 32'h11, "tick_restart_b", -1);

        // Software clear coincident with a limit-hit
        wr(4, 32'd3, "wr_tlim3b");
        wr(0, 32'd0, "wr_tcnt0b");
        wr(8, 32'd0, "clr_all");
        for (int i = 0; i < 10; i++) rd(0, "run_clr");
        wr(8, 32'd0, "clr_on_hit");
        rd_lit(8, 32'h1, "hw_set_wins", -1);

        // Reset mid-count
        rd(0, "pre_mid_reset");
        rd(0, "pre_mid_reset");
        reset = 1'b1;
        rd(0, "mid_reset");
        reset = 1'b0;
        rd_lit(0, 32'h0, "mrst_tcnt", 0);
        rd_lit(4, 32'h0, "mrst_tlim", -1);
        rd_lit(8, 32'h0, "mrst_tctl", -1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            logic [31:0] a, d;
            r = $urandom_range(0, 99);
            a = BASE | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) a = a ^ 32'h1000_0000;
            reset = (r < 2);
            if (r < 70) begin
                do_cycle(1'b0, a, 32'b0, "rand_rd", 1'b0, 32'b0, -1);
            end else begin
                case (a[3:2])
                    2'd0:    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                             : 32'($urandom_range(0, 6));
                    2'd1:    d = 32'($urandom_range(0, 5));
                    default: d = $urandom;
                endcase
                do_cycle(1'b1, a, d, "rand_wr", 1'b0, 32'b0, -1);
            end
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
